// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC engine: mode encoding, binary-angle
// constants and the arctangent table for every micro-rotation stage.
package cordic_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  localparam logic [31:0] ANG_90  = 32'h4000_0000;
  localparam logic [31:0] ANG_180 = 32'h8000_0000;

  // round(atan(2^-i) * 2^32 / 2pi), full circle = 2^32
  localparam logic [31:0] ATAN [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation. Direction comes from the sign of z
// (rotate) or the sign of y (vector); mode travels with the sample.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned SHIFT = 0,
  parameter int unsigned DW    = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 valid_in,
  input  logic                 mode_in,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic [31:0]          z_in,
  output logic                 valid_out,
  output logic                 mode_out,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] y_out,
  output logic [31:0]          z_out
);

  logic signed [DW-1:0] x_sh, y_sh, x_d, y_d, x_q, y_q;
  logic [31:0]          z_d, z_q;
  logic                 valid_q, mode_q;
  logic                 d_neg;

  // Micro-rotation next state; d_neg selects d = -1.
  always_comb begin
    x_sh = x_in >>> SHIFT;
    y_sh = y_in >>> SHIFT;
    if (mode_in == MODE_VECTOR) begin
      d_neg = ~y_in[DW-1];
    end else begin
      d_neg = z_in[31];
    end
    if (d_neg) begin
      x_d = x_in + y_sh;
      y_d = y_in - x_sh;
      z_d = z_in + ATAN[SHIFT];
    end else begin
      x_d = x_in - y_sh;
      y_d = y_in + x_sh;
      z_d = z_in - ATAN[SHIFT];
    end
  end

  // Stage register: reset wins over ce; data loads even for bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else if (ce) begin
      valid_q <= valid_in;
      mode_q  <= mode_in;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign valid_out = valid_q;
  assign mode_out  = mode_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined dual-mode CORDIC: one pre-rotation register stage that folds
// the input into the convergence range, followed by ITER micro-rotation stages.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ITER    = 16,
  parameter int unsigned ANGLE_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic [ANGLE_W-1:0]      z_in,
  output logic                    out_valid,
  output logic                    mode_out,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic [ANGLE_W-1:0]      z_out
);

  localparam int unsigned DW = WIDTH + 2;

  logic signed [DW-1:0] x_ext, y_ext, x0_d, y0_d, x0_q, y0_q;
  logic [31:0]          z0_d, z0_q;
  logic                 v0_q, m0_q;

  logic                 v_s [ITER+1];
  logic                 m_s [ITER+1];
  logic signed [DW-1:0] x_s [ITER+1];
  logic signed [DW-1:0] y_s [ITER+1];
  logic [31:0]          z_s [ITER+1];

  // Pre-rotation: guard-bit extension, quadrant fold (rotate) or half-plane fold (vector).
  always_comb begin
    x_ext = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext = {{2{y_in[WIDTH-1]}}, y_in};
    x0_d  = x_ext;
    y0_d  = y_ext;
    z0_d  = z_in;
    if (mode == MODE_VECTOR) begin
      z0_d = '0;
      if (x_ext[DW-1]) begin
        x0_d = -x_ext;
        y0_d = -y_ext;
        z0_d = ANG_180;
      end
    end else begin
      case (z_in[31:30])
        2'b01: begin
          x0_d = -y_ext;
          y0_d = x_ext;
          z0_d = {2'b00, z_in[29:0]};
        end
        2'b10: begin
          x0_d = y_ext;
          y0_d = -x_ext;
          z0_d = {2'b11, z_in[29:0]};
        end
        default: ;
      endcase
    end
  end

  // Pre-rotation register.
  always_ff @(posedge clock) begin
    if (reset) begin
      v0_q <= 1'b0;
      m0_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
      z0_q <= '0;
    end else if (ce) begin
      v0_q <= in_valid;
      m0_q <= mode;
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
    end
  end

  assign v_s[0] = v0_q;
  assign m_s[0] = m0_q;
  assign x_s[0] = x0_q;
  assign y_s[0] = y0_q;
  assign z_s[0] = z0_q;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(
      .SHIFT (i),
      .DW    (DW)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .ce        (ce),
      .valid_in  (v_s[i]),
      .mode_in   (m_s[i]),
      .x_in      (x_s[i]),
      .y_in      (y_s[i]),
      .z_in      (z_s[i]),
      .valid_out (v_s[i+1]),
      .mode_out  (m_s[i+1]),
      .x_out     (x_s[i+1]),
      .y_out     (y_s[i+1]),
      .z_out     (z_s[i+1])
    );
  end

  assign out_valid = v_s[ITER];
  assign mode_out  = m_s[ITER];
  assign x_out     = x_s[ITER];
  assign y_out     = y_s[ITER];
  assign z_out     = z_s[ITER];

endmodule

// File: tb/tb_cordic_pipe.sv
// Directed bench for cordic_pipe (WIDTH=16, ITER=16). Expected values come from
// ideal real-valued trigonometry scaled by the uncompensated CORDIC gain.
module tb_cordic_pipe;
  import cordic_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 16;
  localparam int unsigned DW    = WIDTH + 2;
  localparam real         PI    = 3.14159265358979323846;

  logic                    clock = 1'b0;
  logic                    reset, ce, in_valid, mode;
  logic signed [WIDTH-1:0] x_in, y_in;
  logic [31:0]             z_in;
  logic                    out_valid, mode_out;
  logic signed [DW-1:0]    x_out, y_out;
  logic [31:0]             z_out;

  typedef struct {
    logic        mode;
    longint      x;
    longint      y;
    logic [31:0] z;
  } smp_t;

  smp_t exp_q[$];
  smp_t got_q[$];
  int   checks = 0;
  int   passes = 0;
  real  k_gain;

  cordic_pipe #(
    .WIDTH   (WIDTH),
    .ITER    (ITER),
    .ANGLE_W (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .mode_out  (mode_out),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input longint obs, input real exp,
                            input longint tol);
    longint e, d;
    logic   ok;
    e  = longint'(exp);
    d  = obs - e;
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) passes++;
    else $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, e, tol);
  endtask

  task automatic check_ang(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                           input longint tol);
    logic signed [31:0] d;
    logic               ok;
    d  = obs - exp;
    ok = (longint'(d) <= tol) && (longint'(d) >= -tol);
    checks++;
    assert (ok === 1'b1) passes++;
    else $error("FAIL %s observed=%0h expected=%0h tol=%0d", tag, obs, exp, tol);
  endtask

  // Ideal result of one sample compared against an observed one.
  task automatic check_result(input string tag, input smp_t s, input smp_t o);
    real         th, ex, ey, a;
    logic [31:0] ez;
    check_eq({tag, "_mode"}, 128'(o.mode), 128'(s.mode));
    if (s.mode == MODE_ROTATE) begin
      th = real'(int'($signed(s.z))) * 2.0 * PI / 4294967296.0;
      ex = k_gain * (real'(s.x) * $cos(th) - real'(s.y) * $sin(th));
      ey = k_gain * (real'(s.x) * $sin(th) + real'(s.y) * $cos(th));
      check_near({tag, "_x"}, o.x, ex, 10);
      check_near({tag, "_y"}, o.y, ey, 10);
      check_ang({tag, "_zres"}, o.z, 32'h0, 64'd131072);
    end else begin
      ex = k_gain * $sqrt(real'(s.x) * real'(s.x) + real'(s.y) * real'(s.y));
      a  = $atan2(real'(s.y), real'(s.x)) / (2.0 * PI) * 4294967296.0;
      ez = 32'(longint'(a));
      check_near({tag, "_mag"}, o.x, ex, 10);
      check_near({tag, "_yres"}, o.y, 0.0, 16);
      check_ang({tag, "_atan"}, o.z, ez, 64'd1048576);
    end
  endtask

  task automatic snap_out(output smp_t o);
    o.mode = mode_out;
    o.x    = longint'(x_out);
    o.y    = longint'(y_out);
    o.z    = z_out;
  endtask

  // One clock: checks hold behaviour under ce=0 and collects accepted results.
  task automatic tick();
    logic         ce_now, rst_now;
    logic [127:0] prev;
    smp_t         o;
    ce_now  = ce;
    rst_now = reset;
    prev    = 128'({out_valid, mode_out, x_out, y_out, z_out});
    @(posedge clock);
    #1;
    if (!ce_now && !rst_now) begin
      check_eq("ce_hold", 128'({out_valid, mode_out, x_out, y_out, z_out}), prev);
    end
    if (ce_now && !rst_now && out_valid) begin
      snap_out(o);
      got_q.push_back(o);
    end
  endtask

  task automatic drive(input logic m, input int x, input int y, input logic [31:0] z);
    mode     = m;
    x_in     = 16'(x);
    y_in     = 16'(y);
    z_in     = z;
    in_valid = 1'b1;
  endtask

  // Single isolated sample: latency, value, and exactly one valid cycle.
  task automatic run_one(input string tag, input logic m, input int x, input int y,
                         input logic [31:0] z);
    int   lat;
    smp_t s, o;
    drive(m, x, y, z);
    s.mode = m;
    s.x    = x;
    s.y    = y;
    s.z    = z;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'(ITER + 1));
    snap_out(o);
    check_result(tag, s, o);
    tick();
    check_eq({tag, "_single"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int   bad;
    int   sx, sy;
    smp_t s;

    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    reset = 1'b1;
    ce    = 1'b1;
    drive(MODE_ROTATE, 0, 0, 32'h0);
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("reset_valid", 128'(out_valid), 128'(0));
    check_eq("reset_outputs", 128'({mode_out, x_out, y_out, z_out}), 128'(0));

    run_one("rot45",    MODE_ROTATE, 19898, 0, 32'h2000_0000);
    run_one("rot135",   MODE_ROTATE, 19898, 0, 32'h6000_0000);
    run_one("rotm135",  MODE_ROTATE, 19898, 0, 32'hA000_0000);
    run_one("vec180",   MODE_VECTOR, -10000, 0, 32'h0);
    run_one("vec45",    MODE_VECTOR, 10000, 10000, 32'h0);
    run_one("vec_edge", MODE_VECTOR, -32768, -32768, 32'h0);

    // Streaming: alternating modes, ce dropped for 3 cycles mid-stream.
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      if (k == 20) begin
        ce = 1'b0;
        drive(MODE_VECTOR, 1234, -4321, 32'hDEAD_BEEF);
        repeat (3) tick();
        ce = 1'b1;
      end
      sx = k[2] ? -1 : 1;
      sy = k[3] ? -1 : 1;
      s.mode = k[0];
      s.x    = sx * (6000 + 150 * k);
      s.y    = sy * (8000 - 100 * k);
      s.z    = 32'(k) * 32'h0ABC_DEF1;
      drive(s.mode, int'(s.x), int'(s.y), s.z);
      exp_q.push_back(s);
      tick();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 60 && got_q.size() < 40; n++) tick();
    repeat (5) tick();
    check_eq("stream_count", 128'(got_q.size()), 128'(40));
    for (int k = 0; k < 40 && k < got_q.size(); k++) begin
      check_result($sformatf("stream%0d", k), exp_q[k], got_q[k]);
    end

    // Reset with samples in flight (ce low too: reset must still win).
    for (int k = 0; k < 10; k++) begin
      drive(MODE_ROTATE, 15000, 1000 * k, 32'h1000_0000);
      tick();
    end
    ce    = 1'b0;
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    check_eq("midreset_valid", 128'(out_valid), 128'(0));
    check_eq("midreset_outputs", 128'({mode_out, x_out, y_out, z_out}), 128'(0));
    bad = 0;
    repeat (25) begin
      tick();
      if (out_valid) bad++;
    end
    check_eq("midreset_no_stale", 128'(bad), 128'(0));
    run_one("post_reset", MODE_ROTATE, 19898, 0, 32'hE000_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
